// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one single-port synchronous data
// memory among NUM_CORES requesters. Accesses take ACCESS (+ RDATA for reads);
// new arbitration overlaps the RDATA cycle so reads sustain one per 2 cycles.
// Optional feature macro: DM_ARB_STATS_EN adds saturating grant/stall counters.
module dm_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  input  logic [DATA_W-1:0]           mem_dout
`ifdef DM_ARB_STATS_EN
  ,
  output logic [NUM_CORES*16-1:0]     grant_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDATA = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   acc_we_q, acc_we_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_din_q, mem_din_d;

  logic                   found;
  logic [IDX_W-1:0]       win;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_CORES);
  endfunction

  // Round-robin search: first set req scanning from ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!found && req[wrap_idx(int'(ptr_q) + k)]) begin
        found = 1'b1;
        win   = wrap_idx(int'(ptr_q) + k);
      end
    end
  end

  // Next-state / output logic; arbitration is open in IDLE and RDATA only.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    acc_we_d   = acc_we_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      ACCESS:  state_d = acc_we_q ? IDLE : RDATA;
      RDATA: begin
        // mem_dout is valid now; return it to the owner of the previous access.
        state_d  = IDLE;
        rvalid_d = NUM_CORES'(1) << idx_q;
        rdata_d  = mem_dout;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE || state_q == RDATA) && found) begin
      state_d    = ACCESS;
      ptr_d      = wrap_idx(int'(win) + 1);
      idx_d      = win;
      acc_we_d   = we[win];
      gnt_d      = NUM_CORES'(1) << win;
      mem_we_d   = we[win];
      mem_addr_d = addr[int'(win)*ADDR_W +: ADDR_W];
      mem_din_d  = wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  // State and output registers; reset discards any in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      acc_we_q   <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      acc_we_q   <= acc_we_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

`ifdef DM_ARB_STATS_EN
  logic [NUM_CORES-1:0][15:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]                stall_cnt_q, stall_cnt_d;

  // Saturating counters: grants per core, and cycles where requests see no grant.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_q[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
    end
    if (|req && !(|gnt_q) && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: reset, round-robin fairness, a table of
// single-core read/write transactions, pointer wrap, and reset during RDATA.
module tb_dm_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_v, we_v;
  logic [31:0] addr_v;
  logic [63:0] wdata_v;
  logic [3:0]  gnt, rvalid;
  logic [15:0] rdata, mem_din, mem_dout;
  logic        mem_we;
  logic [7:0]  mem_addr;
`ifdef DM_ARB_STATS_EN
  logic [63:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  int ntot = 0;
  int npass = 0;

  dm_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .req(req_v), .we(we_v), .addr(addr_v), .wdata(wdata_v),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef DM_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory; unwritten words read as {C0, addr}.
  logic [15:0]  mem [256];
  logic [255:0] written = '0;
  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_din;
      written[mem_addr] <= 1'b1;
    end
    mem_dout <= written[mem_addr] ? mem[mem_addr] : {8'hC0, mem_addr};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_lane(input int c, input logic w, input logic [7:0] a, input logic [15:0] d);
    we_v[c]           = w;
    addr_v[c*8 +: 8]  = a;
    wdata_v[c*16 +: 16] = d;
  endtask

  typedef struct {
    int          core;
    logic        we;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [3:0] eg;
    vt[0] = '{2, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
    vt[1] = '{1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vt[2] = '{0, 1'b1, 8'h20, 16'h1234, 16'h0000};
    vt[3] = '{1, 1'b1, 8'h00, 16'h0000, 16'h0000};
    vt[4] = '{3, 1'b1, 8'hFF, 16'hA5A5, 16'h0000};
    vt[5] = '{3, 1'b0, 8'h20, 16'h0000, 16'h1234};
    vt[6] = '{0, 1'b0, 8'hFF, 16'h0000, 16'hA5A5};
    vt[7] = '{1, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vt[8] = '{2, 1'b0, 8'h10, 16'h0000, 16'hBEEF};

    // Reset held 3 cycles with every core requesting.
    reset = 1'b1; req_v = 4'hF; we_v = 4'h0; addr_v = '0; wdata_v = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", rdata, 0);
    end
    reset = 1'b0; req_v = 4'h0;
    tick();

    // Fairness: all cores read continuously, ptr starts at 0.
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 8'h40 + 8'(i), 16'hDEAD);
    req_v = 4'hF;
    for (int c = 0; c <= 9; c++) begin
      eg = (c % 2 == 1) ? (4'b0001 << ((c - 1) / 2) % 4) : 4'b0000;
      chk($sformatf("fair_gnt_c%0d", c), gnt, eg);
      if (c >= 3 && c % 2 == 1) begin
        chk($sformatf("fair_rvalid_c%0d", c), rvalid, 4'b0001 << ((c - 3) / 2) % 4);
        chk($sformatf("fair_rdata_c%0d", c), rdata, {8'hC0, 8'h40 + 8'(((c - 3) / 2) % 4)});
      end else begin
        chk($sformatf("fair_rvalid_c%0d", c), rvalid, 0);
      end
      if (c < 9) tick();
    end
`ifdef DM_ARB_STATS_EN
    chk("stall_cnt", stall_cnt, 5);
    chk("grant_cnt0", grant_cnt[15:0], 1);
    chk("grant_cnt3", grant_cnt[63:48], 1);
`endif
    req_v = 4'h0;
    tick();
    chk("fair_tail_rvalid0", rvalid, 0);
    tick();
    chk("fair_tail_rvalid", rvalid, 4'b0001);
    chk("fair_tail_rdata", rdata, 16'hC040);
    tick();

    // Table of single-core transactions starting from IDLE.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 4; i++) set_lane(i, ~vt[v].we, 8'hEE, 16'hDEAD);
      set_lane(vt[v].core, vt[v].we, vt[v].a, vt[v].wd);
      req_v = 4'b0001 << vt[v].core;
      chk($sformatf("v%0d_gnt_c0", v), gnt, 0);
      tick();
      chk($sformatf("v%0d_gnt_c1", v), gnt, 4'b0001 << vt[v].core);
      chk($sformatf("v%0d_mem_we_c1", v), mem_we, vt[v].we);
      chk($sformatf("v%0d_mem_addr", v), mem_addr, vt[v].a);
      if (vt[v].we) chk($sformatf("v%0d_mem_din", v), mem_din, vt[v].wd);
      req_v = 4'h0;
      tick();
      chk($sformatf("v%0d_gnt_c2", v), gnt, 0);
      chk($sformatf("v%0d_mem_we_c2", v), mem_we, 0);
      chk($sformatf("v%0d_rvalid_c2", v), rvalid, 0);
      if (!vt[v].we) begin
        tick();
        chk($sformatf("v%0d_rvalid_c3", v), rvalid, 4'b0001 << vt[v].core);
        chk($sformatf("v%0d_rdata", v), rdata, vt[v].exp_rd);
      end
      tick();
    end

    // Wrap: ptr=3 after the last table entry; core3 then core0.
    set_lane(3, 1'b1, 8'h30, 16'h3333);
    set_lane(0, 1'b1, 8'h31, 16'h1111);
    req_v = 4'b1001;
    tick();
    chk("wrap_gnt3", gnt, 4'b1000);
    chk("wrap_addr3", mem_addr, 8'h30);
    chk("wrap_din3", mem_din, 16'h3333);
    tick();
    req_v = 4'b0001;
    chk("wrap_gap", gnt, 0);
    tick();
    chk("wrap_gnt0", gnt, 4'b0001);
    chk("wrap_addr0", mem_addr, 8'h31);
    chk("wrap_we0", mem_we, 1);
    req_v = 4'h0;
    tick();
    chk("wrap_we_off", mem_we, 0);

    // Reset in the RDATA cycle of a core1 read.
    set_lane(1, 1'b0, 8'h30, 16'h0000);
    req_v = 4'b0010;
    tick();
    chk("mrst_gnt", gnt, 4'b0010);
    req_v = 4'h0;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_rvalid", rvalid, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    set_lane(1, 1'b1, 8'h50, 16'h5555);
    set_lane(3, 1'b1, 8'h53, 16'h7777);
    req_v = 4'b1010;
    tick();
    chk("mrst_rvalid_after", rvalid, 0);
    chk("mrst_ptr0_gnt", gnt, 4'b0010);
    chk("mrst_ptr0_addr", mem_addr, 8'h50);
    req_v = 4'h0;
    tick();
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
